// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between fetch_stage and imem.
// master = fetch side, slave = memory side.
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_ready_i, imem_rvalid_i, imem_rdata_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_ready_i, imem_rvalid_i, imem_rdata_i
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage: PC, one-outstanding imem request, hold buffer, IF/ID register.
// Define PERF_CNT_EN to build the stall/flush performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 PCWrite_i,
  input  logic                 Stall_i,
  input  logic                 Flush_i,
  input  logic [31:0]          BranchTarget_i,
  fetch_stage_if.master        imem,
  output logic [31:0]          PC_o,
  output logic [31:0]          IFID_PC_o,
  output logic [31:0]          IFID_Instr_o,
  output logic                 IFID_Valid_o,
  output logic [31:0]          StallCnt_o,
  output logic [31:0]          FlushCnt_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IFID_RST = '{
    pc:    32'h0,
    instr: NOP_INSTR,
    valid: 1'b0
  };

  state_e      state_q, state_d, rst_state;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] buf_q, buf_d;
  if_id_t      ifid_q, ifid_d;

  logic        accept;
  logic        resp;
  logic        load;
  logic [31:0] load_data;

  assign imem.imem_req_o  = (state_q == S_REQ);
  assign imem.imem_addr_o = pc_q;

  assign accept = (state_q == S_REQ) && imem.imem_ready_i;
  assign resp   = imem.imem_rvalid_i;

  // A request still in flight at reset must have its response swallowed.
  always_comb begin
    rst_state = S_REQ;
    if (accept ||
        ((state_q == S_WAIT || state_q == S_DROP) && !resp))
      rst_state = S_DROP;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    buf_d     = buf_q;
    ifid_d    = ifid_q;
    load      = 1'b0;
    load_data = buf_q;
    if (Flush_i) begin
      pc_d         = {BranchTarget_i[31:2], 2'b00};
      ifid_d.instr = NOP_INSTR;
      ifid_d.valid = 1'b0;
      unique case (state_q)
        S_REQ:          state_d = accept ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_d = resp ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (accept) begin
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (resp && Stall_i) begin
            buf_d   = imem.imem_rdata_i;
            state_d = S_HOLD;
          end else if (resp) begin
            load      = 1'b1;
            load_data = imem.imem_rdata_i;
            state_d   = S_REQ;
          end
        end
        S_HOLD: begin
          if (!Stall_i) begin
            load    = 1'b1;
            state_d = S_REQ;
          end
        end
        default: begin
          if (resp) state_d = S_REQ;
        end
      endcase
      if (!Stall_i) begin
        if (load) begin
          ifid_d = '{pc: req_pc_q, instr: load_data, valid: 1'b1};
          if (PCWrite_i) pc_d = req_pc_q + 32'd4;
        end else begin
          ifid_d.instr = NOP_INSTR;
          ifid_d.valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= rst_state;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      buf_q    <= '0;
      ifid_q   <= IFID_RST;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      buf_q    <= buf_d;
      ifid_q   <= ifid_d;
    end
  end

  assign PC_o         = pc_q;
  assign IFID_PC_o    = ifid_q.pc;
  assign IFID_Instr_o = ifid_q.instr;
  assign IFID_Valid_o = ifid_q.valid;

`ifdef PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'b0, Stall_i};
    flush_cnt_d = flush_cnt_q + {31'b0, Flush_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
`else
  assign StallCnt_o = 32'h0;
  assign FlushCnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run
// against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcw;
  logic        stall;
  logic        flush;
  logic [31:0] tgt;
  logic [31:0] PC_o, IFID_PC_o, IFID_Instr_o;
  logic        IFID_Valid_o;
  logic [31:0] StallCnt_o, FlushCnt_o;

  fetch_stage_if imem_if ();

  fetch_stage dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .PCWrite_i      (pcw),
    .Stall_i        (stall),
    .Flush_i        (flush),
    .BranchTarget_i (tgt),
    .imem           (imem_if),
    .PC_o           (PC_o),
    .IFID_PC_o      (IFID_PC_o),
    .IFID_Instr_o   (IFID_Instr_o),
    .IFID_Valid_o   (IFID_Valid_o),
    .StallCnt_o     (StallCnt_o),
    .FlushCnt_o     (FlushCnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [64:0] ifid;
  logic [32:0] ifv;
  logic [32:0] bus;
  logic [63:0] cnt;
  assign ifid = {IFID_PC_o, IFID_Instr_o, IFID_Valid_o};
  assign ifv  = {IFID_Instr_o, IFID_Valid_o};
  assign bus  = {imem_if.imem_req_o, imem_if.imem_addr_o};
  assign cnt  = {StallCnt_o, FlushCnt_o};

  // model: what is in flight, what sits in the buffer, architectural values
  logic        m_busy = 0, m_dead = 0, m_held = 0;
  logic [31:0] m_buf = 0, m_req_pc = 0, m_pc = 0;
  logic [31:0] m_ipc = 0, m_iins = NOP;
  logic        m_ival = 0;
  logic [31:0] m_scnt = 0, m_fcnt = 0;

  // memory: one response pending, delivered after mem_cnt more cycles
  logic        mem_pend = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 0;
  int          mem_lat = 0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  task automatic step(input logic r, input logic s, input logic w,
                      input logic f, input logic [31:0] t,
                      input logic rd);
    logic        rv, mreq, got, acc;
    logic [31:0] rdat, old_pc;
    rv   = mem_pend && (mem_cnt == 0);
    rdat = rv ? word(mem_addr) : 32'hDEAD_BEEF;
    rst = r; stall = s; pcw = w; flush = f; tgt = t;
    imem_if.imem_ready_i  = rd;
    imem_if.imem_rvalid_i = rv;
    imem_if.imem_rdata_i  = rdat;
    mreq   = !m_busy && !m_dead && !m_held;
    acc    = mreq && rd;
    old_pc = m_pc;
    if (r) begin
      m_dead = acc || ((m_busy || m_dead) && !rv);
      m_busy = 0; m_held = 0; m_buf = 0;
      m_pc = 0; m_req_pc = 0;
      m_ipc = 0; m_iins = NOP; m_ival = 0;
      m_scnt = 0; m_fcnt = 0;
    end else begin
      if (s) m_scnt = m_scnt + 1;
      if (f) m_fcnt = m_fcnt + 1;
      if (f) begin
        m_pc = t & ~32'h3;
        m_iins = NOP; m_ival = 0; m_held = 0;
        m_dead = (m_busy || m_dead) ? !rv : acc;
        m_busy = 0;
      end else begin
        got = m_busy && rv;
        if (got && s) begin
          m_buf = rdat; m_held = 1; m_busy = 0;
        end else if (!s) begin
          if (got || m_held) begin
            m_ipc = m_req_pc;
            m_iins = got ? rdat : m_buf;
            m_ival = 1;
            if (w) m_pc = m_req_pc + 4;
            m_busy = 0; m_held = 0;
          end else begin
            m_iins = NOP; m_ival = 0;
          end
        end
        if (m_dead && rv) m_dead = 0;
        if (acc) begin
          m_busy = 1; m_req_pc = old_pc;
        end
      end
    end
    if (rv) mem_pend = 0;
    else if (mem_pend) mem_cnt = mem_cnt - 1;
    if (acc) begin
      mem_pend = 1;
      mem_addr = old_pc;
      mem_cnt  = (mem_lat < 0) ? int'($urandom_range(0, 2)) : mem_lat;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (PC_o !== 32'h0) begin
      errors++; $display("FAIL reset_pc got %h exp 0", PC_o);
    end
    checks++;
    if (bus !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_bus got %h exp %h", bus, {1'b1, 32'h0});
    end
    checks++;
    if (ifid !== {32'h0, NOP, 1'b0}) begin
      errors++; $display("FAIL reset_ifid got %h exp %h", ifid, {32'h0, NOP, 1'b0});
    end
    checks++;
    if (cnt !== 64'h0) begin
      errors++; $display("FAIL reset_cnt got %h exp 0", cnt);
    end
  endtask

  task automatic test_stream();
    mem_lat = 0;
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({bus[32], ifv} !== {1'b0, NOP, 1'b0}) begin
      errors++; $display("FAIL stream_wait got %h", {bus[32], ifv});
    end
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({ifid, bus} !== {32'h0, 32'hA0, 1'b1, 1'b1, 32'h4}) begin
      errors++; $display("FAIL stream_i0 got %h/%h exp 0,a0,1/1,4", ifid, bus);
    end
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if (ifv !== {NOP, 1'b0}) begin
      errors++; $display("FAIL stream_bubble got %h exp %h", ifv, {NOP, 1'b0});
    end
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({ifid, PC_o} !== {32'h4, 32'hA1, 1'b1, 32'h8}) begin
      errors++; $display("FAIL stream_i1 got %h/%h exp 4,a1,1/8", ifid, PC_o);
    end
  endtask

  task automatic test_stall_hold();
    mem_lat = 0;
    step(0, 1, 1, 0, 0, 1);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 0, 1);
      checks++;
      if ({ifid, bus[32], PC_o} !== {32'h4, 32'hA1, 1'b1, 1'b0, 32'h8}) begin
        errors++;
        $display("FAIL stall_hold%0d got %h/%b/%h exp 4,a1,1/0/8", i, ifid, bus[32], PC_o);
      end
    end
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({ifid, bus} !== {32'h8, 32'hA2, 1'b1, 1'b1, 32'hC}) begin
      errors++; $display("FAIL stall_release got %h/%h exp 8,a2,1/1,c", ifid, bus);
    end
  endtask

  task automatic test_flush_wait();
    mem_lat = 1;
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 32'h103, 1);
    checks++;
    if ({PC_o, ifv, bus[32]} !== {32'h100, NOP, 1'b0, 1'b0}) begin
      errors++; $display("FAIL flush_wait got %h/%h/%b exp 100/13,0/0", PC_o, ifv, bus[32]);
    end
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({IFID_Valid_o, bus} !== {1'b0, 1'b1, 32'h100}) begin
      errors++; $display("FAIL flush_stale got %b/%h exp 0/1,100", IFID_Valid_o, bus);
    end
    mem_lat = 0;
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if (ifid !== {32'h100, word(32'h100), 1'b1}) begin
      errors++; $display("FAIL flush_refetch got %h exp 100,%h,1", ifid, word(32'h100));
    end
  endtask

  task automatic test_flush_stall();
    mem_lat = 0;
    step(0, 1, 1, 0, 0, 1);
    step(0, 1, 1, 1, 32'h200, 1);
    checks++;
    if ({PC_o, ifv, bus} !== {32'h200, NOP, 1'b0, 1'b1, 32'h200}) begin
      errors++; $display("FAIL flush_stall got %h/%h/%h exp 200/13,0/1,200", PC_o, ifv, bus);
    end
  endtask

  task automatic test_counters();
    logic [63:0] exp;
`ifdef PERF_CNT_EN
    exp = {32'd5, 32'd2};
`else
    exp = 64'h0;
`endif
    checks++;
    if (cnt !== exp) begin
      errors++; $display("FAIL counters got %h exp %h", cnt, exp);
    end
  endtask

  task automatic test_wrap();
    mem_lat = 0;
    step(0, 0, 1, 1, 32'hFFFF_FFFF, 0);
    checks++;
    if (bus !== {1'b1, 32'hFFFF_FFFC}) begin
      errors++; $display("FAIL wrap_addr got %h exp 1,fffffffc", bus);
    end
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({ifid, bus} !== {32'hFFFF_FFFC, word(32'hFFFF_FFFC), 1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL wrap_next got %h/%h exp next addr 0", ifid, bus);
    end
  endtask

  task automatic test_pcwrite0();
    mem_lat = 0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    checks++;
    if ({ifid, bus} !== {32'h0, 32'hA0, 1'b1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL pcwrite0 got %h/%h exp 0,a0,1/1,0", ifid, bus);
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 1;
    step(0, 0, 1, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    checks++;
    if ({ifid, PC_o} !== {32'h0, NOP, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rst_mid got %h/%h exp 0,13,0/0", ifid, PC_o);
    end
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if ({IFID_Valid_o, bus} !== {1'b0, 1'b1, 32'h0}) begin
      errors++; $display("FAIL rst_stale got %b/%h exp 0/1,0", IFID_Valid_o, bus);
    end
    mem_lat = 0;
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    checks++;
    if (ifid !== {32'h0, 32'hA0, 1'b1}) begin
      errors++; $display("FAIL rst_refetch got %h exp 0,a0,1", ifid);
    end
  endtask

  task automatic test_random();
    logic [63:0] exp_cnt;
    mem_lat = -1;
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 8,
           $urandom, $urandom_range(0, 99) < 70);
`ifdef PERF_CNT_EN
      exp_cnt = {m_scnt, m_fcnt};
`else
      exp_cnt = 64'h0;
`endif
      checks++;
      if ({ifid, PC_o, bus} !== {m_ipc, m_iins, m_ival, m_pc, ~(m_busy | m_dead | m_held), m_pc}) begin
        errors++;
        $display("FAIL rand%0d got ifid %h pc %h bus %h exp ifid %h pc %h req %b",
                 n, ifid, PC_o, bus, {m_ipc, m_iins, m_ival}, m_pc,
                 ~(m_busy | m_dead | m_held));
      end
      checks++;
      if (cnt !== exp_cnt) begin
        errors++; $display("FAIL rand_cnt%0d got %h exp %h", n, cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1; pcw = 1; stall = 0; flush = 0; tgt = 0;
    imem_if.imem_ready_i  = 0;
    imem_if.imem_rvalid_i = 0;
    imem_if.imem_rdata_i  = 0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall_hold();
    test_flush_wait();
    test_flush_stall();
    test_counters();
    test_wrap();
    test_pcwrite0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage with PC register and IF/ID pipeline register, directly upstream of the ID stage and its hazard detection unit. It issues one instruction-memory request at a time, captures the returned word into IF/ID, and obeys the hazard unit's PCWrite/Stall outputs and the ID stage's branch flush. A one-entry holding buffer absorbs a memory response that arrives while IF/ID is stalled.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven on IF/ID when invalid
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- PCWrite_i  in  1  hazard unit; 0 = PC must not advance
- Stall_i  in  1  hazard unit; 1 = IF/ID must hold its contents
- Flush_i  in  1  ID stage branch taken; redirect and kill younger fetch
- BranchTarget_i  in  32  redirect address; bits [1:0] ignored (forced 0)
- imem_req_o  out  1  request valid
- imem_addr_o  out  32  request address (word aligned)
- imem_ready_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  response valid; never earlier than the cycle after acceptance
- imem_rdata_i  in  32  response instruction
- PC_o  out  32  current fetch PC
- IFID_PC_o  out  32  PC of instruction in IF/ID
- IFID_Instr_o  out  32  instruction in IF/ID
- IFID_Valid_o  out  1  IF/ID holds a real instruction
- StallCnt_o  out  32  stall-cycle counter (see Configuration)
- FlushCnt_o  out  32  flush counter (see Configuration)

## Operation
- States: REQ, WAIT, HOLD, DROP.
- REQ: imem_req_o=1, imem_addr_o=PC_o. On imem_ready_i -> WAIT; request PC latched as req_pc.
- WAIT: on imem_rvalid_i: if Stall_i=0, load IF/ID {req_pc, rdata, 1}, PC_o <= req_pc+4 if PCWrite_i=1, -> REQ. If Stall_i=1, store rdata in hold buffer -> HOLD.
- HOLD: imem_req_o=0. When Stall_i=0: load buffer into IF/ID, PC_o <= req_pc+4 if PCWrite_i=1, -> REQ.
- DROP: wait for the outstanding response, discard it, -> REQ. IF/ID and PC are not touched by the discarded word.
- IF/ID advance without new instruction (Stall_i=0, nothing loaded): IF/ID <= {PC unchanged, NOP_INSTR, 0}.
- Stall_i=1: IF/ID holds all three fields unchanged.
- PCWrite_i=0 with Stall_i=0: the instruction is still loaded into IF/ID but PC_o holds; the same address is refetched.
- Flush_i=1 (highest priority, overrides Stall_i and PCWrite_i): PC_o <= {BranchTarget_i[31:2],2'b00}; IF/ID <= bubble; REQ without accept -> REQ; REQ with imem_ready_i same cycle -> DROP; WAIT without rvalid -> DROP; WAIT with rvalid same cycle -> word discarded, -> REQ; HOLD -> buffer discarded, -> REQ.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset values: state REQ, PC_o=RESET_PC, imem_req_o=1 from the first cycle after reset, imem_addr_o=RESET_PC, IFID_PC_o=0, IFID_Instr_o=NOP_INSTR, IFID_Valid_o=0, counters 0.
- rst_i mid-transaction: return to reset values; the next imem_rvalid_i for the pre-reset request is ignored (reset enters DROP if a request was outstanding, else REQ).
- Latency: with imem_ready_i=1 and rvalid one cycle after accept, instruction visible on IF/ID 2 cycles after request; throughput 1 instruction / 2 cycles.
- imem_addr_o stable while imem_req_o=1 and imem_ready_i=0, unless Flush_i redirects.
- Outputs are registered except imem_req_o/imem_addr_o, which decode from state and PC.

## Configuration
- PERF_CNT_EN defined: StallCnt_o increments every cycle with Stall_i=1 and rst_i=0; FlushCnt_o increments per Flush_i cycle; both wrap at 2^32, reset to 0.
- Not defined: no counter registers; StallCnt_o and FlushCnt_o tied to 32'h0.

## Test plan
- Reset, memory ready=1, rvalid 1 cycle after accept, words 0xA0.. -> IF/ID shows (0x0,0xA0,1), (0x4,0xA1,1) every 2 cycles; bubbles between.
- Stall_i=1 for 3 cycles while response arrives in WAIT -> state HOLD, IF/ID unchanged, no new request; Stall_i drops -> buffered word loads next edge, PC_o=req_pc+4.
- Flush_i with BranchTarget_i=0x103 while in WAIT -> PC_o=0x100, IFID_Valid_o=0, stale rvalid discarded, next request at 0x100.
- Flush_i and Stall_i both 1 same cycle -> flush behaviour, IF/ID bubble.
- RESET_PC=0xFFFF_FFFC -> second request address 0x0000_0000.
- With PERF_CNT_EN, 5 stall cycles and 2 flushes -> StallCnt_o=5, FlushCnt_o=2; without, both 0.
